// File: rtl/mem_responder.sv
// Memory-side responder: owns MAR/MDR and a word-addressed RAM, serves bus read/write strobes
// with WAIT_CYCLES wait states and a one-cycle done pulse. Optional: MEM_BOUNDS_CHECK_EN.
module mem_responder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_BITS   = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  mari,
    input  logic                  mdri,
    input  logic                  mdro,
    input  logic                  read,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic [DATA_WIDTH-1:0] mar_q,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] mdr;
    logic [3:0]            wait_cnt;
    logic                  is_wr;
    logic                  fault;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // MAR and MDR are frozen while busy, so they double as the captured address and write data.
`ifdef MEM_BOUNDS_CHECK_EN
    assign fault = |mar[DATA_WIDTH-1:ADDR_BITS];
`else
    assign fault = 1'b0;
`endif

    assign mar_q   = mar;
    assign bus_out = mdro ? mdr : '0;

    // Control FSM with registered busy/done/err
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            mar      <= '0;
            mdr      <= '0;
            wait_cnt <= 4'd0;
            is_wr    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mari) mar <= bus_in;
                    if (mdri) mdr <= bus_in;
                    if (read || write) begin
                        is_wr    <= write;
                        busy     <= 1'b1;
                        wait_cnt <= 4'd0;
                        state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 4'd0;
                        state    <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!is_wr && !fault) mdr <= mem[mar[ADDR_BITS-1:0]];
                    done  <= 1'b1;
                    err   <= fault;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM write port; reset at the ACCESS edge aborts the commit
    always_ff @(posedge clock) begin
        if (reset && state == S_ACCESS && is_wr && !fault) begin
            mem[mar[ADDR_BITS-1:0]] <= mdr;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// compared against an abstract memory/register model.
module tb_mem_responder;

    localparam int unsigned W = 2;
`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] bus_in;
    logic        mari, mdri, mdro, read, write;
    logic [31:0] bus_out, mar_q;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [512];
    logic [31:0] mar_m, mdr_m;

    mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(9), .WAIT_CYCLES(W)) dut (
        .clock(clock), .reset(reset), .bus_in(bus_in), .mari(mari), .mdri(mdri),
        .mdro(mdro), .read(read), .write(write), .bus_out(bus_out), .mar_q(mar_q),
        .busy(busy), .done(done), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        mari = 1'b0; mdri = 1'b0; mdro = 1'b0; read = 1'b0; write = 1'b0; bus_in = '0;
    endtask

    task automatic load_mar(input logic [31:0] a);
        bus_in = a; mari = 1'b1; tick(); mari = 1'b0; mar_m = a;
    endtask

    task automatic load_mdr(input logic [31:0] d);
        bus_in = d; mdri = 1'b1; tick(); mdri = 1'b0; mdr_m = d;
    endtask

    task automatic junk_inputs();
        mari = 1'($urandom); mdri = 1'($urandom); mdro = 1'($urandom);
        read = 1'($urandom); write = 1'($urandom); bus_in = $urandom;
    endtask

    // One complete request issued from IDLE; checks timing, lockout and results
    task automatic op(input bit wr, input bit rd, input bit byp, input logic [31:0] a, input bit junk);
        logic [31:0] pre_mdr;
        int unsigned idx;
        bit oob;
        read = rd; write = wr; mari = byp; mdri = 1'b0; bus_in = byp ? a : $urandom;
        if (byp) mar_m = a;
        tick();
        clear_inputs();
        idx = mar_m % 512;
        oob = BOUNDS && ((mar_m / 512) != 0);
        pre_mdr = mdr_m;
        if (wr) begin
            if (!oob) mem_m[idx] = mdr_m;
        end else if (!oob) begin
            mdr_m = mem_m[idx];
        end
        for (int i = 0; i <= int'(W); i++) begin
            chk("busy_during", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            if (junk) begin
                junk_inputs();
                #1;
                if (mdro) chk("bus_pre_access", bus_out, pre_mdr);
            end
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("err_with_done", 32'(err), 32'(oob));
        chk("busy_in_done", 32'(busy), 32'd1);
        if (junk) junk_inputs();
        mdro = 1'b1;
        #1;
        chk("bus_after_access", bus_out, mdr_m);
        tick();
        clear_inputs();
        chk("done_cleared", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("err_cleared", 32'(err), 32'd0);
        chk("mar_locked", mar_q, mar_m);
    endtask

    task automatic show_mdr(input string tag, input logic [31:0] exp);
        mdro = 1'b1;
        #1;
        chk(tag, bus_out, exp);
        mdro = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bit wr, rd;
        reset = 1'b0;
        clear_inputs();
        mar_m = '0; mdr_m = '0;
        tick(); tick();
        chk("rst_mar", mar_q, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        show_mdr("rst_mdr", 32'h0);
        reset = 1'b1;
        tick();

        // Write/read round trip
        load_mar(32'h10);
        load_mdr(32'hDEADBEEF);
        op(1'b1, 1'b0, 1'b0, '0, 1'b0);
        load_mdr(32'h0);
        op(1'b0, 1'b1, 1'b0, '0, 1'b0);
        show_mdr("roundtrip", 32'hDEADBEEF);

        // Fill the working window with distinct values, with junk strobes while busy
        for (int i = 0; i < 64; i++) begin
            load_mar(32'(i));
            load_mdr(32'(i) * 32'h01010101 ^ 32'h5A5A0000);
            op(1'b1, 1'b0, 1'b0, '0, 1'b1);
        end

        // Bypass: address from bus in the request cycle
        load_mar(32'h10);
        op(1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
        chk("bypass_mar", mar_q, 32'h20);
        show_mdr("bypass_data", 32'h20202020 ^ 32'h5A5A0000);

        // Priority: write wins over read
        load_mar(32'h21);
        load_mdr(32'h12345678);
        op(1'b1, 1'b1, 1'b0, '0, 1'b0);
        show_mdr("prio_mdr_kept", 32'h12345678);
        load_mdr(32'h0);
        op(1'b0, 1'b1, 1'b0, '0, 1'b0);
        show_mdr("prio_written", 32'h12345678);

        // Lockout: mari with 0x55 while busy
        load_mar(32'h22);
        write = 1'b1; tick(); write = 1'b0;
        mem_m[32'h22] = mdr_m;
        bus_in = 32'h55; mari = 1'b1; tick(); mari = 1'b0;
        chk("lockout_mar", mar_q, 32'h22);
        for (int i = 0; i < int'(W) + 1; i++) tick();
        chk("lockout_idle", 32'(busy), 32'd0);

        // Reset during WAIT of a write aborts it
        load_mar(32'h30);
        load_mdr(32'h1);
        op(1'b1, 1'b0, 1'b0, '0, 1'b0);
        load_mdr(32'h77);
        write = 1'b1; tick(); write = 1'b0;
        reset = 1'b0; tick(); reset = 1'b1;
        mar_m = '0; mdr_m = '0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_mar", mar_q, 32'h0);
        load_mar(32'h30);
        op(1'b0, 1'b1, 1'b0, '0, 1'b0);
        show_mdr("rst_mid_mem", 32'h1);

        // Wrap or bounds fault at 0x205
        load_mar(32'h5);
        load_mdr(32'h11);
        op(1'b1, 1'b0, 1'b0, '0, 1'b0);
        load_mar(32'h205);
        load_mdr(32'hA5);
        op(1'b1, 1'b0, 1'b0, '0, 1'b0);
        load_mar(32'h5);
        op(1'b0, 1'b1, 1'b0, '0, 1'b0);
        show_mdr("wrap_bounds", BOUNDS ? 32'h11 : 32'hA5);

        // Randomized back-to-back traffic
        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 3) == 0) ? (($urandom << 9) | 32'($urandom_range(0, 63)))
                                            : 32'($urandom_range(0, 63));
            d = $urandom;
            wr = 1'($urandom);
            rd = wr ? 1'($urandom) : 1'b1;
            if ($urandom_range(0, 1) == 1) load_mdr(d);
            if ($urandom_range(0, 1) == 1) begin
                op(wr, rd, 1'b1, a, 1'b1);
            end else begin
                load_mar(a);
                op(wr, rd, 1'b0, '0, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
